// File: rtl/lv_pkg.sv
// Shared lv definitions: register-file geometry, CRC-8 constants and the
// watchdog register-scan FSM state encoding.
package lv_pkg;

    localparam int LV_REG_AW    = 7;
    localparam int LV_REG_DW    = 8;
    localparam int LV_REG_CRC_W = 8;

    localparam logic [7:0] LV_CRC8_POLY = 8'h07;
    localparam logic [7:0] LV_CRC8_INIT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_REQ   = 2'd2,
        ST_CHECK = 2'd3
    } lv_wdg_scan_state_e;

endpackage

// File: rtl/lv_crc8.sv
// Combinational CRC-8 (MSB-first, no reflection, no final XOR) over one
// register word; shared with the register file.
module lv_crc8
    import lv_pkg::*;
#(
    parameter int DATA_W = LV_REG_DW,
    parameter int CRC_W  = LV_REG_CRC_W
) (
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc
);

    function automatic logic [CRC_W-1:0] crc8_calc(input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        c = CRC_W'(LV_CRC8_INIT);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ d[i])
                c = {c[CRC_W-2:0], 1'b0} ^ CRC_W'(LV_CRC8_POLY);
            else
                c = {c[CRC_W-2:0], 1'b0};
        end
        return c;
    endfunction

    assign crc = crc8_calc(data);

endmodule

// File: rtl/lv_wdg_reg_scan.sv
// Watchdog register scanner: periodically reads a register address range
// through the arbiter and checks each word against its stored CRC-8.
module lv_wdg_reg_scan
    import lv_pkg::*;
#(
    parameter int                REG_AW          = LV_REG_AW,
    parameter int                REG_DW          = LV_REG_DW,
    parameter int                REG_CRC_W       = LV_REG_CRC_W,
    parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
    parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h1F,
    parameter int                SCAN_PERIOD     = 1000,
    parameter int                ACK_TIMEOUT     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scan_en,
    input  logic                 i_spi_rst_wdg,
    output logic                 o_wdg_scan_reg_rd_req,
    output logic [REG_AW-1:0]    o_wdg_scan_reg_addr,
    input  logic                 i_reg_wdg_scan_ack,
    input  logic [REG_DW-1:0]    i_reg_wdg_scan_data,
    input  logic [REG_CRC_W-1:0] i_reg_wdg_scan_crc,
    output logic                 o_scan_crc_err,
    output logic [REG_AW-1:0]    o_scan_err_addr,
    output logic                 o_scan_timeout,
    output logic                 o_scan_done,
    output logic                 o_scan_busy,
    output logic [3:0]           o_crc_err_cnt
);

    localparam int PER_W = $clog2(SCAN_PERIOD);
    localparam int TMO_W = $clog2(ACK_TIMEOUT);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    lv_wdg_scan_state_e state, state_nxt;

    logic [PER_W-1:0]     per_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [REG_AW-1:0]    addr;
    logic [REG_AW-1:0]    err_addr;
    logic [3:0]           err_cnt;
    logic                 req;
    logic                 crc_err;
    logic                 tmo_pulse;
    logic                 done;
    logic                 crc_skip;
    logic [REG_DW-1:0]    cap_data_p1;
    logic [REG_CRC_W-1:0] cap_crc_p1;
    logic [REG_CRC_W-1:0] crc_calc;
    logic                 ack_take;
    logic                 tmo_hit;
    logic                 crc_mismatch;
    logic                 last_addr;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    lv_crc8 #(
        .DATA_W (REG_DW),
        .CRC_W  (REG_CRC_W)
    ) u_crc8 (
        .data (cap_data_p1),
        .crc  (crc_calc)
    );

    assign ack_take     = (state == ST_REQ) && i_reg_wdg_scan_ack;
    assign tmo_hit      = (state == ST_REQ) && !i_reg_wdg_scan_ack && (tmo_cnt == TMO_LAST);
    assign crc_mismatch = !crc_skip && (crc_calc != cap_crc_p1);
    assign last_addr    = (addr == SCAN_END_ADDR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // A timeout also passes through CHECK (with the CRC compare skipped) so
    // req drops for one cycle before the next address is requested.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_scan_en) state_nxt = ST_WAIT;
            ST_WAIT:  if (!i_spi_rst_wdg && per_cnt == PER_LAST) state_nxt = ST_REQ;
            ST_REQ:   if (ack_take || tmo_hit) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = last_addr ? ST_WAIT : ST_REQ;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!i_scan_en)
            state_nxt = ST_IDLE;
    end

    always_comb begin
        o_scan_busy = (state == ST_REQ) || (state == ST_CHECK);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            per_cnt   <= '0;
            tmo_cnt   <= '0;
            addr      <= SCAN_START_ADDR;
            err_addr  <= '0;
            err_cnt   <= '0;
            req       <= 1'b0;
            crc_err   <= 1'b0;
            tmo_pulse <= 1'b0;
            done      <= 1'b0;
            crc_skip  <= 1'b0;
        end else begin
            req       <= (state_nxt == ST_REQ);
            crc_err   <= 1'b0;
            tmo_pulse <= 1'b0;
            done      <= 1'b0;
            per_cnt   <= (state == ST_WAIT && !i_spi_rst_wdg) ? per_cnt + PER_W'(1) : '0;
            tmo_cnt   <= (state == ST_REQ) ? tmo_cnt + TMO_W'(1) : '0;
            if (!i_scan_en) begin
                addr     <= SCAN_START_ADDR;
                crc_skip <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (state_nxt == ST_REQ)
                            addr <= SCAN_START_ADDR;
                    end
                    ST_REQ: begin
                        if (ack_take) begin
                            crc_skip <= 1'b0;
                        end else if (tmo_hit) begin
                            crc_skip  <= 1'b1;
                            tmo_pulse <= 1'b1;
                            err_addr  <= addr;
                        end
                    end
                    ST_CHECK: begin
                        if (crc_mismatch) begin
                            crc_err  <= 1'b1;
                            err_addr <= addr;
                            err_cnt  <= sat_inc4(err_cnt);
                        end
                        if (last_addr)
                            done <= 1'b1;
                        else
                            addr <= addr + REG_AW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Capture stage: read word and stored CRC held for the CHECK cycle
    always_ff @(posedge i_clk) begin
        if (ack_take) begin
            cap_data_p1 <= i_reg_wdg_scan_data;
            cap_crc_p1  <= i_reg_wdg_scan_crc;
        end
    end

    assign o_wdg_scan_reg_rd_req = req;
    assign o_wdg_scan_reg_addr   = addr;
    assign o_scan_crc_err        = crc_err;
    assign o_scan_err_addr       = err_addr;
    assign o_scan_timeout        = tmo_pulse;
    assign o_scan_done           = done;
    assign o_crc_err_cnt         = err_cnt;

endmodule
